spike_flit_injector: RTL and testbench
======================================

# spike_flit_injector

Parametrised local-port injector between one or more neuron-core packet sources and the router local input. Accepts whole spike packets from N_SRC sources with round-robin arbitration and buffers them in a DEPTH-entry FIFO. Serialises each packet into FLIT_W-bit flits on the router write/full handshake. Supersedes the fixed single-source 32-bit/4-bit local path: it adds multiple sources, configurable widths and depth, and a selectable drop-on-full mode with a drop counter.

## Interface
- PACKET_W, 32, packet width in bits; must be an integer multiple of FLIT_W.
- FLIT_W, 4, flit width in bits; FLITS = PACKET_W/FLIT_W, and FLITS must be at least 2.
- N_SRC, 2, number of packet sources, 1..8.
- DEPTH, 8, FIFO entries; must be a power of 2.
- DEPTH_BITS, 3, log2(DEPTH).
- DROP_ON_FULL, 0, 0 = backpressure sources; 1 = always accept, and discard when full.

Ports:
- clk  in  1  single clock, shared by the neuron and the router local port.
- rst_n  in  1  synchronous reset, active low.
- src_valid  in  N_SRC  per-source packet valid.
- src_packet  in  N_SRC*PACKET_W  source i occupies bits [i*PACKET_W +: PACKET_W].
- src_ready  out  N_SRC  one-hot grant; a packet transfers when valid & ready.
- flit_out  out  FLIT_W  flit to the router local_in.
- write_req  out  1  flit valid; the transfer occurs in any cycle where it is 1.
- router_full  in  1  router local FIFO full.
- fifo_count  out  DEPTH_BITS+1  occupancy, excluding the packet in flight.
- drop_cnt  out  8  saturating count of discarded packets.
- idle  out  1  FIFO empty and serialiser in IDLE.

## Operation
- **Arbiter**
  - Each cycle, grant at most one valid source, round-robin.
  - The priority pointer starts at source 0 after reset and moves to granted+1 (mod N_SRC) after each grant.
  - With DROP_ON_FULL=0: src_ready is all-zero when fifo_count == DEPTH.
  - With DROP_ON_FULL=1: a grant is always issued. If the FIFO is full, the packet is discarded and drop_cnt increments, saturating at 255.
  - No push bypass: full status is evaluated before the same-cycle pop.
- **FIFO**
  - Circular buffer with DEPTH_BITS-bit read/write pointers that wrap modulo DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
- **Serialiser FSM**
  - IDLE: when fifo_count > 0, pop the head into a PACKET_W shift register, set flit_idx = 0, and go to SEND.
  - SEND: flit_out = shreg[PACKET_W-1 -: FLIT_W] (MSB flit first, so the address flit leads).
  - On each transfer, shift left by FLIT_W and increment flit_idx.
  - On a transfer with flit_idx == FLITS-1: if FIFO is non-empty, pop the next packet in the same cycle and stay in SEND (no bubble); otherwise go to IDLE.
  - write_req = (state == SEND) & ~router_full, combinational. flit_out holds its value while stalled.
- **Reset**
  - On a clk edge with rst_n = 0: pointers, count, FSM (IDLE), shift register, RR pointer and drop_cnt all clear.
  - An in-flight packet is abandoned mid-packet; no partial flits follow after reset.

## Timing
- Reset values: src_ready = 0, flit_out = 0, write_req = 0, fifo_count = 0, drop_cnt = 0, idle = 1.
- src_ready is a combinational function of src_valid, the RR pointer and fifo_count.
- Latency, empty injector, router not full:
  - Packet accepted at edge E0.
  - Serialiser loads at E1.
  - First flit has write_req = 1 in the cycle after E1.
  - Last flit at E1 + FLITS cycles.
- Throughput: one flit per cycle sustained, so one packet per FLITS cycles with no inter-packet gap.
- Backpressure: router_full = 1 freezes the shift register and flit_idx. write_req drops in the same cycle, and transfer resumes the cycle router_full clears.
- idle rises the cycle after the last flit transfers with the FIFO empty.

## Test plan
- **Single packet:** defaults, src 0 sends 0x12345678, router_full = 0.
  - flit_out sequence 1,2,3,4,5,6,7,8 on 8 consecutive write_req cycles, starting 2 cycles after accept.
  - idle = 1 afterwards.
- **Round-robin:** both sources held valid with 0xA..., 0xB... packets.
  - Grants alternate 0,1,0,1.
  - Output packets interleave A,B,A,B with zero gap cycles between packets.
- **Backpressure/full:** DROP_ON_FULL = 0, router_full held 1, src 0 pushes 10 packets.
  - src_ready falls after 8 are stored, with fifo_count = 8 and one packet in the shift register (9 accepted in total).
  - Release router_full: all 9 packets emerge in order with no loss.
- **Drop mode:** DROP_ON_FULL = 1, same stimulus as above.
  - 9 accepted; drop_cnt = 1 after the 10th.
  - Repeat 300 overflows: drop_cnt saturates at 255.
- **Mid-packet stall:** assert router_full after flit 3 for 5 cycles.
  - write_req = 0 and flit_out holds 4 throughout the stall.
  - Flits 4..8 follow without duplication.
- **Reset mid-operation:** rst_n low for 1 cycle during flit 5 with 3 packets queued.
  - Next cycle: write_req = 0, fifo_count = 0, idle = 1.
  - No stale flits after a new packet is injected.

Source files
------------

// File: rtl/spike_flit_injector.sv
`default_nettype none
// ============================================================================
//  Module      : spike_flit_injector
//  Description : Round-robin multi-source spike packet injector with a
//                packet FIFO and an MSB-first flit serialiser for the router
//                local input port.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_flit_injector #(
    parameter int PACKET_W     = 32,
    parameter int FLIT_W       = 4,
    parameter int N_SRC        = 2,
    parameter int DEPTH        = 8,
    parameter int DEPTH_BITS   = 3,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*PACKET_W-1:0] src_packet,
    output logic [N_SRC-1:0]          src_ready,
    output logic [FLIT_W-1:0]         flit_out,
    output logic                      write_req,
    input  logic                      router_full,
    output logic [DEPTH_BITS:0]       fifo_count,
    output logic [7:0]                drop_cnt,
    output logic                      idle
);

    localparam int c_FLITS = PACKET_W / FLIT_W;
    localparam int c_IDX_W = $clog2(c_FLITS);
    localparam int c_SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SEND = 1'b1;

    logic [PACKET_W-1:0]   w_src_pkt [N_SRC];
    logic [PACKET_W-1:0]   r_mem     [DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic [c_SRC_W-1:0]    r_rr_ptr;
    logic [0:0]            r_state;
    logic [PACKET_W-1:0]   r_shreg;
    logic [c_IDX_W-1:0]    r_flit_idx;

    logic                  w_any_valid;
    logic [c_SRC_W-1:0]    w_grant_idx;
    logic [c_SRC_W-1:0]    w_cand;
    logic [c_SRC_W-1:0]    w_next_rr;
    logic                  w_grant_en;
    logic                  w_full;
    logic                  w_nempty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_xfer;
    logic                  w_last_xfer;
    logic [PACKET_W-1:0]   w_head;
    logic [PACKET_W-1:0]   w_shifted;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
            assign w_src_pkt[gi] = src_packet[gi*PACKET_W +: PACKET_W];
        end
    endgenerate

    // Scan from the priority pointer; iterating downward leaves the closest
    // valid source (smallest offset) as the final winner.
    always_comb begin
        w_any_valid = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            w_cand = c_SRC_W'((int'(r_rr_ptr) + k) % N_SRC);
            if (src_valid[w_cand]) begin
                w_any_valid = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_next_rr = c_SRC_W'((int'(w_grant_idx) + 1) % N_SRC);
    assign w_full    = (r_count == (DEPTH_BITS+1)'(DEPTH));
    assign w_nempty  = (r_count != '0);
    assign src_ready = w_grant_en ? (N_SRC'(1) << w_grant_idx) : '0;
    assign w_push    = w_grant_en & ~w_full;

    generate
        if (DROP_ON_FULL != 0) begin : g_drop
            logic [7:0] r_drop_cnt;

            assign w_grant_en = w_any_valid;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_drop_cnt <= '0;
                end else if (w_any_valid && w_full && (r_drop_cnt != 8'hFF)) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end

            assign drop_cnt = r_drop_cnt;
        end else begin : g_backpressure
            assign w_grant_en = w_any_valid & ~w_full;
            assign drop_cnt   = 8'd0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_grant_en) begin
            r_rr_ptr <= w_next_rr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_src_pkt[w_grant_idx];
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_xfer      = (r_state == c_ST_SEND) & ~router_full;
    assign w_last_xfer = w_xfer & (r_flit_idx == c_IDX_W'(c_FLITS - 1));
    // Popping on the last flit keeps back-to-back packets gap-free.
    assign w_pop       = w_nempty & ((r_state == c_ST_IDLE) | w_last_xfer);
    assign w_shifted   = {r_shreg[PACKET_W-FLIT_W-1:0], {FLIT_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_shreg    <= '0;
            r_flit_idx <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_nempty) begin
                        r_shreg    <= w_head;
                        r_flit_idx <= '0;
                        r_state    <= c_ST_SEND;
                    end
                end
                c_ST_SEND: begin
                    if (w_last_xfer) begin
                        r_flit_idx <= '0;
                        if (w_nempty) begin
                            r_shreg <= w_head;
                        end else begin
                            r_shreg <= w_shifted;
                            r_state <= c_ST_IDLE;
                        end
                    end else if (w_xfer) begin
                        r_shreg    <= w_shifted;
                        r_flit_idx <= r_flit_idx + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign flit_out   = r_shreg[PACKET_W-1 -: FLIT_W];
    assign write_req  = w_xfer;
    assign fifo_count = r_count;
    assign idle       = ~w_nempty & (r_state == c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spike_flit_injector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_flit_injector
//  Description : Scoreboard bench for spike_flit_injector (backpressure and
//                drop-on-full instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_flit_injector;

    logic        clk;
    logic        rst_n;
    logic [1:0]  src_valid;
    logic [63:0] src_packet;
    logic [1:0]  src_ready;
    logic [3:0]  flit_out;
    logic        write_req;
    logic        router_full;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_cnt;
    logic        idle;

    logic [1:0]  d_src_valid;
    logic [63:0] d_src_packet;
    logic [1:0]  d_src_ready;
    logic [3:0]  d_flit_out;
    logic        d_write_req;
    logic        d_router_full;
    logic [3:0]  d_fifo_count;
    logic [7:0]  d_drop_cnt;
    logic        d_idle;

    spike_flit_injector #(
        .PACKET_W(32), .FLIT_W(4), .N_SRC(2), .DEPTH(8), .DEPTH_BITS(3), .DROP_ON_FULL(0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_packet(src_packet),
        .src_ready(src_ready), .flit_out(flit_out), .write_req(write_req),
        .router_full(router_full), .fifo_count(fifo_count), .drop_cnt(drop_cnt), .idle(idle)
    );

    spike_flit_injector #(
        .PACKET_W(32), .FLIT_W(4), .N_SRC(2), .DEPTH(8), .DEPTH_BITS(3), .DROP_ON_FULL(1)
    ) u_dut_drop (
        .clk(clk), .rst_n(rst_n), .src_valid(d_src_valid), .src_packet(d_src_packet),
        .src_ready(d_src_ready), .flit_out(d_flit_out), .write_req(d_write_req),
        .router_full(d_router_full), .fifo_count(d_fifo_count), .drop_cnt(d_drop_cnt),
        .idle(d_idle)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          flit_cnt = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    logic [3:0]  sb_q [$];
    int          grant_q [$];
    logic [31:0] mon_pkt;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Accepted packets expand to MSB-first flits; every router write pops one.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    mon_pkt = src_packet[i*32 +: 32];
                    grant_q.push_back(i);
                    for (int f = 0; f < 8; f++) sb_q.push_back(mon_pkt[31-4*f -: 4]);
                end
            end
            if (write_req) begin
                flit_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (sb_q.size() == 0) check("flit_unexpected", 32'(sb_q.size()), 32'd1);
                else                  check("flit", {28'd0, flit_out}, {28'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic send_pkt(input int src, input logic [31:0] pkt);
        bit ok = 1'b0;
        src_packet[src*32 +: 32] = pkt;
        src_valid[src] = 1'b1;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (src_ready[src]) ok = 1'b1;
        end
        check("accept", {31'd0, ok}, 32'd1);
        if (ok) begin
            @(posedge clk);
            #1;
        end
        src_valid[src] = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int n = 0; n < 600 && !ok; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && idle) ok = 1'b1;
        end
        check("drain", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_grant [4] = '{0, 1, 0, 1};
        rst_n = 1'b0; src_valid = '0; src_packet = '0; router_full = 1'b0;
        d_src_valid = '0; d_src_packet = '0; d_router_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_src_ready", {30'd0, src_ready}, 32'd0);
        check("rst_flit_out",  {28'd0, flit_out}, 32'd0);
        check("rst_write_req", {31'd0, write_req}, 32'd0);
        check("rst_fifo_count", {28'd0, fifo_count}, 32'd0);
        check("rst_drop_cnt",  {24'd0, d_drop_cnt}, 32'd0);
        check("rst_idle",      {31'd0, idle}, 32'd1);
        check("rst_idle_drop", {31'd0, d_idle}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single packet and latency
        flit_cnt = 0;
        send_pkt(0, 32'h12345678);
        @(negedge clk);
        check("lat_e0_wr", {31'd0, write_req}, 32'd0);
        check("lat_e0_count", {28'd0, fifo_count}, 32'd1);
        @(negedge clk);
        check("lat_first_wr", {31'd0, write_req}, 32'd1);
        check("lat_first_flit", {28'd0, flit_out}, 32'd1);
        wait_drain();
        check("single_flits", 32'(flit_cnt), 32'd8);
        check("single_idle", {31'd0, idle}, 32'd1);

        // Round-robin, gap-free interleave
        do_reset();
        grant_q.delete(); flit_cnt = 0; first_cyc = -1;
        src_packet = {32'hB1B2B3B4, 32'hA1A2A3A4};
        src_valid = 2'b11;
        repeat (4) @(posedge clk);
        #1 src_valid = 2'b00;
        wait_drain();
        check("rr_grant_cnt", 32'(grant_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < grant_q.size()) check("rr_grant", 32'(grant_q[i]), 32'(exp_grant[i]));
        check("rr_flits", 32'(flit_cnt), 32'd32);
        check("rr_span", 32'(last_cyc - first_cyc), 32'd31);

        // Backpressure until full
        router_full = 1'b1; flit_cnt = 0;
        for (int k = 0; k < 9; k++) send_pkt(0, 32'h13579BDF ^ (32'(k) * 32'h11111111));
        src_packet[31:0] = 32'hFEDCBA98;
        src_valid[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_ready", {30'd0, src_ready}, 32'd0);
            check("full_wr", {31'd0, write_req}, 32'd0);
        end
        check("full_count", {28'd0, fifo_count}, 32'd8);
        @(posedge clk);
        #1 src_valid[0] = 1'b0; router_full = 1'b0;
        wait_drain();
        check("full_flits", 32'(flit_cnt), 32'd72);

        // Mid-packet stall after flit 3
        flit_cnt = 0;
        send_pkt(0, 32'h12345678);
        repeat (4) @(posedge clk);
        #1 router_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_wr", {31'd0, write_req}, 32'd0);
            check("stall_flit", {28'd0, flit_out}, 32'd4);
        end
        @(posedge clk);
        #1 router_full = 1'b0;
        wait_drain();
        check("stall_flits", 32'(flit_cnt), 32'd8);

        // Reset during flit 5 with 3 packets queued
        router_full = 1'b1;
        send_pkt(0, 32'h12345678);
        send_pkt(1, 32'h2468ACE0);
        send_pkt(0, 32'h0F1E2D3C);
        send_pkt(1, 32'h55AA33CC);
        @(negedge clk);
        check("mid_queued", {28'd0, fifo_count}, 32'd3);
        @(posedge clk);
        #1 router_full = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_wr", {31'd0, write_req}, 32'd0);
        check("mid_rst_count", {28'd0, fifo_count}, 32'd0);
        check("mid_rst_idle", {31'd0, idle}, 32'd1);
        @(posedge clk);
        #1 flit_cnt = 0;
        send_pkt(1, 32'h9ABCDEF0);
        wait_drain();
        check("mid_new_flits", 32'(flit_cnt), 32'd8);

        // Drop-on-full instance
        d_router_full = 1'b1;
        d_src_packet[31:0] = 32'hCAFEF00D;
        d_src_valid = 2'b01;
        repeat (10) begin
            @(negedge clk);
            check("drop_ready", {30'd0, d_src_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        d_src_valid = 2'b00;
        @(negedge clk);
        check("drop_count", {28'd0, d_fifo_count}, 32'd8);
        check("drop_cnt_1", {24'd0, d_drop_cnt}, 32'd1);
        @(posedge clk);
        #1 d_src_valid = 2'b01;
        repeat (300) @(posedge clk);
        #1 d_src_valid = 2'b00;
        @(negedge clk);
        check("drop_cnt_sat", {24'd0, d_drop_cnt}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
